cpu_controller: RTL
===================

Name: cpu_controller

Overview:
- Multicycle control FSM for the 16-bit RISC core.
- Sits directly downstream of the instruction decoder. It consumes the decoded opcode and op fields and drives every datapath, instruction-register, program-counter and memory control strobe.
- Sequences fetch, PC update, decode and execute for MOV, ALU, LDR, STR and HALT.
- Includes a memory-ready handshake with an optional wait timeout.

Parameters:
- WAIT_LIMIT, 0: maximum cycles to wait for mem_rdy in a memory state. 0 means wait forever.
- WCNT_W, 8: width of the wait counter. WAIT_LIMIT must be less than 2**WCNT_W.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- opcode  in  3  instruction[15:13] from decoder
- op  in  2  instruction[12:11] from decoder (op/ALUop)
- mem_rdy  in  1  memory completed the current command this cycle
- load_ir  out  1  instruction register load
- load_pc  out  1  PC load
- reset_pc  out  1  PC next value = 0 (else PC+1)
- addr_sel  out  1  1 = memory address from PC, 0 = from data address register
- load_addr  out  1  data address register load (from C)
- mem_cmd  out  2  00 none, 01 read, 10 write
- nsel  out  3  one-hot register select: 001 Rn, 010 Rd, 100 Rm
- vsel  out  4  one-hot writeback source: 0001 C, 0010 PC, 0100 sximm8, 1000 mdata
- write  out  1  register file write enable
- loada, loadb, loadc, loads  out  1 each  datapath register loads
- asel  out  1  1 = ALU A input forced to 0
- bsel  out  1  1 = ALU B input = sximm5
- alu_force_add  out  1  override ALUop with ADD
- retire  out  1  one-cycle pulse in the final cycle of each instruction
- halted  out  1  high in HALT state
- err  out  1  sticky: memory wait timeout occurred

Behaviour:
- Moore FSM. All outputs decode from state only, except retire, which also uses opcode/op.
- Any output not listed for a state is 0. mem_cmd defaults to 00.
- reset (synchronous) forces state RST, clears the wait counter and clears err. It overrides everything, including mid-instruction and HALT.
- RST: reset_pc=1, load_pc=1 → IF1. After reset, all other outputs are 0.
- IF1: addr_sel=1, mem_cmd=01. Go to IF2 when mem_rdy=1, else stay.
- IF2: addr_sel=1, mem_cmd=01, load_ir=1 → UPC.
- UPC: load_pc=1 (PC+1) → DEC.
- DEC: no strobes. Next state by fields:
  - 110/10 → MOVI
  - 110/00 → GETB
  - 101/11 → GETB
  - 101/other → GETA
  - 011 or 100 → GETA
  - 111 → HALT
  - anything else → IF1 with retire=1 (NOP)
- MOVI: nsel=001, vsel=0100, write=1, retire → IF1.
- GETA: nsel=001, loada=1. Next is ADDR for 011/100, else GETB.
- GETB: nsel=100, loadb=1 → ALU.
- ALU: asel=1 for 110/00 or 101/11, else 0. bsel=0.
  - For CMP (101/01): loads=1, retire → IF1.
  - Otherwise: loadc=1 → WB.
- WB: nsel=010, vsel=0001, write=1, retire → IF1.
- ADDR: bsel=1, alu_force_add=1, loadc=1 → LADDR.
- LADDR: load_addr=1. Next is LDMEM for 011, STGET for 100.
- LDMEM: addr_sel=0, mem_cmd=01. Go to LDWB when mem_rdy=1.
- LDWB: mem_cmd=01, nsel=010, vsel=1000, write=1, retire → IF1.
- STGET: nsel=010, loadb=1 → STPASS.
- STPASS: asel=1, bsel=0, loadc=1 → STMEM.
- STMEM: addr_sel=0, mem_cmd=10. Go to IF1 with retire when mem_rdy=1.
- HALT: halted=1, retire=1 on entry cycle only. Stays in HALT until reset.
- Wait counter: increments in IF1/LDMEM/STMEM while mem_rdy=0, and clears on any state change.
  - When WAIT_LIMIT≠0 and the counter reaches WAIT_LIMIT with mem_rdy still 0, go to HALT and set err=1.
  - mem_rdy=1 on the limit cycle wins: normal transition, no err.
- Fields are sampled in DEC and each later state directly from inputs. The decoder is fed from the IR, which is stable until the next IF2.
- Latencies (cycles, fetch included, zero-wait memory):
  - MOV imm 5; MOV reg/MVN 7; ADD/AND 8; CMP 7; LDR 9; STR 10.

Decomposition:
- cpu_pkg holds:
  - state enum (5-bit)
  - opcode constants: OP_MOV=110, OP_ALU=101, OP_LDR=011, OP_STR=100, OP_HALT=111
  - ALU op codes: ADD 00, CMP 01, AND 10, MVN 11
  - one-hot nsel/vsel constants
  - mem_cmd encodings
- Optional sub-module mem_wait_timer (counter, limit compare, sticky err).

Test Plan:
- Reset, then opcode=110 op=10 with mem_rdy=1: states RST,IF1,IF2,UPC,DEC,MOVI; MOVI has nsel=001, vsel=0100, write=1, retire=1; total 6 cycles after reset.
- opcode=101 op=00 (ADD): GETA loada/nsel=001, GETB loadb/nsel=100, ALU loadc=1 asel=0, WB write=1 nsel=010 vsel=0001; retire once.
- opcode=101 op=01 (CMP): ALU state loads=1, loadc=0, no write; returns to IF1 next cycle.
- opcode=011 with mem_rdy low 3 cycles in LDMEM: mem_cmd=01, addr_sel=0 held 4 cycles; LDWB vsel=1000 write=1; STR path shows mem_cmd=10 in STMEM.
- WAIT_LIMIT=4, mem_rdy tied 0 in IF1: HALT after 4 wait cycles, err=1, halted=1; then reset=1 → RST with err=0.
- opcode=111: HALT, retire pulse once, halted stays 1 for 20 cycles; reset asserted mid-GETB of an ADD goes to RST next cycle, no write issued.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared encodings for the multicycle controller: state enum, instruction fields,
// one-hot register/writeback selects and memory command codes.
package cpu_pkg;

    typedef enum logic [4:0] {
        StRst,
        StIf1,
        StIf2,
        StUpc,
        StDec,
        StMovi,
        StGetA,
        StGetB,
        StAlu,
        StWb,
        StAddr,
        StLaddr,
        StLdMem,
        StLdWb,
        StStGet,
        StStPass,
        StStMem,
        StHalt,
        StHaltHold
    } state_e;

    localparam logic [2:0] OP_MOV  = 3'b110;
    localparam logic [2:0] OP_ALU  = 3'b101;
    localparam logic [2:0] OP_LDR  = 3'b011;
    localparam logic [2:0] OP_STR  = 3'b100;
    localparam logic [2:0] OP_HALT = 3'b111;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_CMP = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_MVN = 2'b11;

    // MOV sub-forms share the op field with the ALU encodings
    localparam logic [1:0] MOV_IMM = ALU_AND;
    localparam logic [1:0] MOV_REG = ALU_ADD;

    localparam logic [2:0] NSEL_RN = 3'b001;
    localparam logic [2:0] NSEL_RD = 3'b010;
    localparam logic [2:0] NSEL_RM = 3'b100;

    localparam logic [3:0] VSEL_C     = 4'b0001;
    localparam logic [3:0] VSEL_PC    = 4'b0010;
    localparam logic [3:0] VSEL_IMM   = 4'b0100;
    localparam logic [3:0] VSEL_MDATA = 4'b1000;

    localparam logic [1:0] MEM_NONE  = 2'b00;
    localparam logic [1:0] MEM_READ  = 2'b01;
    localparam logic [1:0] MEM_WRITE = 2'b10;

endpackage

// File: rtl/cpu_controller_if.sv
// Decoder/memory inputs and datapath control strobes of the controller.
interface cpu_controller_if;

    logic [2:0] opcode;
    logic [1:0] op;
    logic       mem_rdy;
    logic       load_ir;
    logic       load_pc;
    logic       reset_pc;
    logic       addr_sel;
    logic       load_addr;
    logic [1:0] mem_cmd;
    logic [2:0] nsel;
    logic [3:0] vsel;
    logic       write;
    logic       loada;
    logic       loadb;
    logic       loadc;
    logic       loads;
    logic       asel;
    logic       bsel;
    logic       alu_force_add;
    logic       retire;
    logic       halted;
    logic       err;

    modport master (
        input  opcode, op, mem_rdy,
        output load_ir, load_pc, reset_pc, addr_sel, load_addr, mem_cmd, nsel, vsel, write,
               loada, loadb, loadc, loads, asel, bsel, alu_force_add, retire, halted, err
    );

    modport slave (
        output opcode, op, mem_rdy,
        input  load_ir, load_pc, reset_pc, addr_sel, load_addr, mem_cmd, nsel, vsel, write,
               loada, loadb, loadc, loads, asel, bsel, alu_force_add, retire, halted, err
    );

endinterface

// File: rtl/cpu_controller_mem_wait_timer.sv
// Counts cycles spent waiting on mem_rdy and holds a sticky timeout error flag.
module cpu_controller_mem_wait_timer #(
    parameter int unsigned WAIT_LIMIT = 0,
    parameter int unsigned WCNT_W     = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic count,
    input  logic clear,
    input  logic set_err,
    output logic at_limit,
    output logic err
);

    localparam logic [WCNT_W-1:0] Limit = WCNT_W'(WAIT_LIMIT);

    logic [WCNT_W-1:0] cnt_q, cnt_d;
    logic              err_q, err_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (count) begin
            cnt_d = cnt_q + WCNT_W'(1);
        end
        err_d = err_q | set_err;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    // A zero limit disables the timeout entirely
    assign at_limit = (WAIT_LIMIT != 0) && (cnt_q == Limit);
    assign err      = err_q;

endmodule

// File: rtl/cpu_controller.sv
// Multicycle control FSM: fetch, PC update, decode and execute for MOV/ALU/LDR/STR/HALT,
// with a mem_rdy handshake and optional wait timeout.
module cpu_controller
    import cpu_pkg::*;
#(
    parameter int unsigned WAIT_LIMIT = 0,
    parameter int unsigned WCNT_W     = 8
) (
    input logic            clk,
    input logic            reset,
    cpu_controller_if.master bus
);

    state_e state_q, state_d;
    logic   mem_state, at_limit, timeout, err;
    logic   is_mov_imm, is_mov_reg, is_mvn, is_cmp, is_mem;

    assign is_mov_imm = (bus.opcode == OP_MOV) && (bus.op == MOV_IMM);
    assign is_mov_reg = (bus.opcode == OP_MOV) && (bus.op == MOV_REG);
    assign is_mvn     = (bus.opcode == OP_ALU) && (bus.op == ALU_MVN);
    assign is_cmp     = (bus.opcode == OP_ALU) && (bus.op == ALU_CMP);
    assign is_mem     = (bus.opcode == OP_LDR) || (bus.opcode == OP_STR);

    assign mem_state = state_q inside {StIf1, StLdMem, StStMem};
    // mem_rdy on the limit cycle still wins over the timeout
    assign timeout   = mem_state && !bus.mem_rdy && at_limit;

    cpu_controller_mem_wait_timer #(
        .WAIT_LIMIT(WAIT_LIMIT),
        .WCNT_W    (WCNT_W)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .count   (mem_state && !bus.mem_rdy),
        .clear   (state_d != state_q),
        .set_err (timeout),
        .at_limit(at_limit),
        .err     (err)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StRst;
        end else begin
            state_q <= state_d;
        end
    end

    assign bus.err = err;

    always_comb begin
        state_d           = state_q;
        bus.load_ir       = 1'b0;
        bus.load_pc       = 1'b0;
        bus.reset_pc      = 1'b0;
        bus.addr_sel      = 1'b0;
        bus.load_addr     = 1'b0;
        bus.mem_cmd       = MEM_NONE;
        bus.nsel          = 3'b000;
        bus.vsel          = 4'b0000;
        bus.write         = 1'b0;
        bus.loada         = 1'b0;
        bus.loadb         = 1'b0;
        bus.loadc         = 1'b0;
        bus.loads         = 1'b0;
        bus.asel          = 1'b0;
        bus.bsel          = 1'b0;
        bus.alu_force_add = 1'b0;
        bus.retire        = 1'b0;
        bus.halted        = 1'b0;

        case (state_q)
            StRst: begin
                bus.reset_pc = 1'b1;
                bus.load_pc  = 1'b1;
                state_d      = StIf1;
            end
            StIf1: begin
                bus.addr_sel = 1'b1;
                bus.mem_cmd  = MEM_READ;
                if (bus.mem_rdy) state_d = StIf2;
                else if (timeout) state_d = StHaltHold;
            end
            StIf2: begin
                bus.addr_sel = 1'b1;
                bus.mem_cmd  = MEM_READ;
                bus.load_ir  = 1'b1;
                state_d      = StUpc;
            end
            StUpc: begin
                bus.load_pc = 1'b1;
                state_d     = StDec;
            end
            StDec: begin
                if (is_mov_imm) state_d = StMovi;
                else if (is_mov_reg || is_mvn) state_d = StGetB;
                else if ((bus.opcode == OP_ALU) || is_mem) state_d = StGetA;
                else if (bus.opcode == OP_HALT) state_d = StHalt;
                else begin
                    bus.retire = 1'b1;
                    state_d    = StIf1;
                end
            end
            StMovi: begin
                bus.nsel   = NSEL_RN;
                bus.vsel   = VSEL_IMM;
                bus.write  = 1'b1;
                bus.retire = 1'b1;
                state_d    = StIf1;
            end
            StGetA: begin
                bus.nsel  = NSEL_RN;
                bus.loada = 1'b1;
                state_d   = is_mem ? StAddr : StGetB;
            end
            StGetB: begin
                bus.nsel  = NSEL_RM;
                bus.loadb = 1'b1;
                state_d   = StAlu;
            end
            StAlu: begin
                bus.asel = is_mov_reg || is_mvn;
                if (is_cmp) begin
                    bus.loads  = 1'b1;
                    bus.retire = 1'b1;
                    state_d    = StIf1;
                end else begin
                    bus.loadc = 1'b1;
                    state_d   = StWb;
                end
            end
            StWb: begin
                bus.nsel   = NSEL_RD;
                bus.vsel   = VSEL_C;
                bus.write  = 1'b1;
                bus.retire = 1'b1;
                state_d    = StIf1;
            end
            StAddr: begin
                bus.bsel          = 1'b1;
                bus.alu_force_add = 1'b1;
                bus.loadc         = 1'b1;
                state_d           = StLaddr;
            end
            StLaddr: begin
                bus.load_addr = 1'b1;
                state_d       = (bus.opcode == OP_LDR) ? StLdMem : StStGet;
            end
            StLdMem: begin
                bus.mem_cmd = MEM_READ;
                if (bus.mem_rdy) state_d = StLdWb;
                else if (timeout) state_d = StHaltHold;
            end
            StLdWb: begin
                bus.mem_cmd = MEM_READ;
                bus.nsel    = NSEL_RD;
                bus.vsel    = VSEL_MDATA;
                bus.write   = 1'b1;
                bus.retire  = 1'b1;
                state_d     = StIf1;
            end
            StStGet: begin
                bus.nsel  = NSEL_RD;
                bus.loadb = 1'b1;
                state_d   = StStPass;
            end
            StStPass: begin
                bus.asel  = 1'b1;
                bus.loadc = 1'b1;
                state_d   = StStMem;
            end
            StStMem: begin
                bus.mem_cmd = MEM_WRITE;
                if (bus.mem_rdy) begin
                    bus.retire = 1'b1;
                    state_d    = StIf1;
                end else if (timeout) begin
                    state_d = StHaltHold;
                end
            end
            // Split HALT so the retire pulse only marks the instruction's own entry
            StHalt: begin
                bus.halted = 1'b1;
                bus.retire = 1'b1;
                state_d    = StHaltHold;
            end
            StHaltHold: begin
                bus.halted = 1'b1;
            end
            default: state_d = StRst;
        endcase
    end

endmodule
